// File: rtl/remote_pkg.sv
// remote_pkg: shared types and constants for the remote command sender and its UART transceiver.
package remote_pkg;

  typedef enum logic [1:0] {IDLE, TX_HI, TX_LO, WAIT_RESP} rcs_state_t;

  localparam logic [7:0] RESP_DONE = 8'hA5;
  localparam logic [7:0] RESP_PROG = 8'h5A;

  localparam int unsigned BAUD_CNT_W = 13;
  localparam int unsigned BIT_CNT_W  = 4;
  localparam int unsigned TO_CNT_W   = 25;

endpackage

// File: rtl/uart_byte_xcvr.sv
// uart_byte_xcvr: 8N1 UART byte transmitter and receiver sharing one baud divisor.
// tx_done is a same-cycle strobe so the next frame can start with no idle gap.
module uart_byte_xcvr #(
  parameter int unsigned BAUD_DIV = 5208
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       trmt,
  input  logic [7:0] tx_data,
  output logic       tx_done,
  output logic       TX,
  input  logic       RX,
  output logic [7:0] rx_data,
  output logic       rx_vld,
  output logic       frm_err
);
  import remote_pkg::*;

  localparam logic [BAUD_CNT_W-1:0] BAUD_LAST = BAUD_CNT_W'(BAUD_DIV - 1);
  localparam logic [BAUD_CNT_W-1:0] BAUD_HALF = BAUD_CNT_W'(BAUD_DIV / 2 - 1);
  localparam logic [BIT_CNT_W-1:0]  BIT_STOP  = BIT_CNT_W'(9);
  localparam logic [BIT_CNT_W-1:0]  BIT_ONE   = BIT_CNT_W'(1);

  logic                  tx_busy;
  logic [BAUD_CNT_W-1:0] tx_baud;
  logic [BIT_CNT_W-1:0]  tx_bit;
  logic [8:0]            tx_shift;

  logic                  rx_ff1, rx_s, rx_prev;
  logic                  rx_busy;
  logic [BAUD_CNT_W-1:0] rx_baud;
  logic [BIT_CNT_W-1:0]  rx_bit;
  logic [7:0]            rx_shift;

  assign tx_done = tx_busy && (tx_baud == BAUD_LAST) && (tx_bit == BIT_STOP);

  // Transmitter: a new trmt takes priority so back-to-back frames abut.
  always_ff @(posedge clk) begin
    if (rst) begin
      TX       <= 1'b1;
      tx_busy  <= 1'b0;
      tx_baud  <= '0;
      tx_bit   <= '0;
      tx_shift <= '1;
    end else if (trmt) begin
      TX       <= 1'b0;
      tx_busy  <= 1'b1;
      tx_baud  <= '0;
      tx_bit   <= '0;
      tx_shift <= {1'b1, tx_data};
    end else if (tx_busy) begin
      if (tx_baud == BAUD_LAST) begin
        tx_baud <= '0;
        if (tx_bit == BIT_STOP) begin
          tx_busy <= 1'b0;
        end else begin
          TX       <= tx_shift[0];
          tx_shift <= {1'b1, tx_shift[8:1]};
          tx_bit   <= tx_bit + 1'b1;
        end
      end else begin
        tx_baud <= tx_baud + 1'b1;
      end
    end
  end

  // RX synchroniser plus one extra stage for falling-edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_ff1  <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_ff1  <= RX;
      rx_s    <= rx_ff1;
      rx_prev <= rx_s;
    end
  end

  // Receiver: bit 0 is the half-period start re-check, bits 1..8 data, bit 9 stop.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_busy  <= 1'b0;
      rx_baud  <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
      rx_data  <= '0;
      rx_vld   <= 1'b0;
      frm_err  <= 1'b0;
    end else begin
      rx_vld  <= 1'b0;
      frm_err <= 1'b0;
      if (!rx_busy) begin
        if (rx_prev && !rx_s) begin
          rx_busy <= 1'b1;
          rx_baud <= '0;
          rx_bit  <= '0;
        end
      end else if (rx_bit == '0) begin
        if (rx_baud == BAUD_HALF) begin
          rx_baud <= '0;
          if (rx_s) rx_busy <= 1'b0;
          else      rx_bit  <= BIT_ONE;
        end else begin
          rx_baud <= rx_baud + 1'b1;
        end
      end else if (rx_baud == BAUD_LAST) begin
        rx_baud <= '0;
        if (rx_bit == BIT_STOP) begin
          rx_busy <= 1'b0;
          if (rx_s) begin
            rx_vld  <= 1'b1;
            rx_data <= rx_shift;
          end else begin
            frm_err <= 1'b1;
          end
        end else begin
          rx_shift <= {rx_s, rx_shift[7:1]};
          rx_bit   <= rx_bit + 1'b1;
        end
      end else begin
        rx_baud <= rx_baud + 1'b1;
      end
    end
  end

endmodule

// File: rtl/remote_cmd_sender.sv
// remote_cmd_sender: sends a 16-bit command as two UART bytes (high first) and collects response bytes.
// Optional response timeout is built when RESP_TIMEOUT_EN is defined.
module remote_cmd_sender #(
  parameter int unsigned BAUD_DIV    = 5208,
  parameter int unsigned TIMEOUT_CYC = 2**24
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] cmd,
  input  logic        snd_cmd,
  output logic        busy,
  output logic        cmd_snt,
  output logic [7:0]  resp,
  output logic        resp_rdy,
  output logic        timeout,
  output logic        TX,
  input  logic        RX
);
  import remote_pkg::*;

  if (BAUD_DIV < 16 || TIMEOUT_CYC < 2) begin : g_bad_param
    $error("remote_cmd_sender: BAUD_DIV must be >= 16 and TIMEOUT_CYC >= 2");
  end

  rcs_state_t state, state_nxt;

  logic       trmt_c;
  logic [7:0] tx_byte_c;
  logic       tx_done;
  logic [7:0] rx_data;
  logic       rx_vld;
  logic       frm_err;
  logic       rx_ok_c;
  logic       to_hit_c;
  logic       cmd_snt_nxt, resp_rdy_nxt, timeout_nxt;
  logic [7:0] cmd_lo;

  uart_byte_xcvr #(.BAUD_DIV(BAUD_DIV)) u_xcvr (
    .clk     (clk),
    .rst     (rst),
    .trmt    (trmt_c),
    .tx_data (tx_byte_c),
    .tx_done (tx_done),
    .TX      (TX),
    .RX      (RX),
    .rx_data (rx_data),
    .rx_vld  (rx_vld),
    .frm_err (frm_err)
  );

  // Framing errors never count as a response.
  assign rx_ok_c = rx_vld && !frm_err;

`ifdef RESP_TIMEOUT_EN
  logic [TO_CNT_W-1:0] to_cnt;

  assign to_hit_c = (to_cnt == TO_CNT_W'(TIMEOUT_CYC - 1));

  // Held at zero outside WAIT_RESP so it starts fresh on entry; restarts on each valid byte.
  always_ff @(posedge clk) begin
    if (rst || state != WAIT_RESP || rx_ok_c) to_cnt <= '0;
    else                                     to_cnt <= to_cnt + 1'b1;
  end
`else
  assign to_hit_c = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (snd_cmd) state_nxt = TX_HI;
      TX_HI:     if (tx_done) state_nxt = TX_LO;
      TX_LO:     if (tx_done) state_nxt = WAIT_RESP;
      WAIT_RESP: begin
        if (rx_ok_c) begin
          if (rx_data != RESP_PROG) state_nxt = IDLE;
        end else if (to_hit_c) begin
          state_nxt = IDLE;
        end
      end
      default:   state_nxt = IDLE;
    endcase
  end

  // The high byte goes straight from the cmd input so TX falls one clock after the request.
  always_comb begin
    trmt_c       = 1'b0;
    tx_byte_c    = cmd[15:8];
    cmd_snt_nxt  = 1'b0;
    resp_rdy_nxt = 1'b0;
    timeout_nxt  = 1'b0;
    case (state)
      IDLE:      trmt_c = snd_cmd;
      TX_HI: begin
        trmt_c    = tx_done;
        tx_byte_c = cmd_lo;
      end
      TX_LO:     cmd_snt_nxt = tx_done;
      WAIT_RESP: begin
        resp_rdy_nxt = rx_ok_c;
        timeout_nxt  = !rx_ok_c && to_hit_c;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy     <= 1'b0;
      cmd_snt  <= 1'b0;
      resp     <= '0;
      resp_rdy <= 1'b0;
      timeout  <= 1'b0;
      cmd_lo   <= '0;
    end else begin
      busy     <= (state_nxt != IDLE);
      cmd_snt  <= cmd_snt_nxt;
      resp_rdy <= resp_rdy_nxt;
      timeout  <= timeout_nxt;
      if (resp_rdy_nxt)            resp   <= rx_data;
      if (state == IDLE && snd_cmd) cmd_lo <= cmd[7:0];
    end
  end

endmodule

// File: tb/tb_remote_cmd_sender.sv
// tb_remote_cmd_sender: directed bench for remote_cmd_sender with BAUD_DIV=16, TIMEOUT_CYC=2000.
module tb_remote_cmd_sender;
  import remote_pkg::*;

  localparam int unsigned BD = 16;
  localparam int unsigned TO = 2000;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] cmd;
  logic        snd_cmd;
  logic        busy, cmd_snt, resp_rdy, timeout, TX;
  logic [7:0]  resp;
  logic        RX;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rdy_cnt = 0;
  int snt_cnt = 0;
  int to_cnt = 0;
  int tx_frm_bad = 0;
  logic [7:0] tx_q[$];
  bit   tm_act = 1'b0;
  int   tm_idx = 0;
  int   tm_pos = 0;
  logic [7:0] tm_sh = '0;

  remote_cmd_sender #(.BAUD_DIV(BD), .TIMEOUT_CYC(TO)) dut (
    .clk      (clk),
    .rst      (rst),
    .cmd      (cmd),
    .snd_cmd  (snd_cmd),
    .busy     (busy),
    .cmd_snt  (cmd_snt),
    .resp     (resp),
    .resp_rdy (resp_rdy),
    .timeout  (timeout),
    .TX       (TX),
    .RX       (RX)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse counters, sampled away from the active edge.
  always @(negedge clk) begin
    if (resp_rdy === 1'b1) rdy_cnt++;
    if (cmd_snt === 1'b1)  snt_cnt++;
    if (timeout === 1'b1)  to_cnt++;
  end

  // TX line decoder: samples each bit mid-period and queues completed bytes.
  always @(negedge clk) begin
    if (rst !== 1'b0) begin
      tm_act = 1'b0;
    end else if (!tm_act) begin
      if (TX === 1'b0) begin
        tm_act = 1'b1;
        tm_idx = 0;
      end
    end else begin
      tm_idx++;
      if (tm_idx % BD == BD / 2) begin
        tm_pos = tm_idx / BD;
        if (tm_pos == 0) begin
          if (TX !== 1'b0) tm_act = 1'b0;
        end else if (tm_pos <= 8) begin
          tm_sh = {TX, tm_sh[7:1]};
        end else begin
          tx_q.push_back(tm_sh);
          if (TX !== 1'b1) tx_frm_bad++;
          tm_act = 1'b0;
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_cmd(input logic [15:0] c, output int t0);
    cmd     = c;
    snd_cmd = 1'b1;
    t0      = cyc;
    @(negedge clk);
    snd_cmd = 1'b0;
  endtask

  task automatic wait_snt(output int t);
    t = -1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (cmd_snt === 1'b1) begin
        t = cyc;
        break;
      end
    end
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop);
    RX = 1'b0;
    tick(BD);
    for (int i = 0; i < 8; i++) begin
      RX = b[i];
      tick(BD);
    end
    RX = stop;
    tick(BD);
    RX = 1'b1;
  endtask

  initial begin
    int t0, ts, n, tt;
    rst = 1'b1; snd_cmd = 1'b0; cmd = '0; RX = 1'b1;
    tick(3);
    chk("rst_tx",       32'(TX),       32'd1);
    chk("rst_busy",     32'(busy),     32'd0);
    chk("rst_cmd_snt",  32'(cmd_snt),  32'd0);
    chk("rst_resp",     32'(resp),     32'h00);
    chk("rst_resp_rdy", 32'(resp_rdy), 32'd0);
    chk("rst_timeout",  32'(timeout),  32'd0);
    rst = 1'b0;
    tick(2);

    // 1: single command, done reply
    send_cmd(16'h2345, t0);
    chk("t1_tx_start", 32'(TX),   32'd0);
    chk("t1_busy",     32'(busy), 32'd1);
    wait_snt(ts);
    chk("t1_snt_lat",  32'(ts - t0),      32'd321);
    chk("t1_nbytes",   32'(tx_q.size()),  32'd2);
    chk("t1_byte_hi",  32'(tx_q[0]),      32'h23);
    chk("t1_byte_lo",  32'(tx_q[1]),      32'h45);
    chk("t1_busy_wait", 32'(busy),        32'd1);
    tx_q.delete();
    n = rdy_cnt;
    send_rx(RESP_DONE, 1'b1);
    tick(2);
    chk("t1_rdy_cnt", 32'(rdy_cnt - n), 32'd1);
    chk("t1_resp",    32'(resp),        32'(RESP_DONE));
    chk("t1_busy_end", 32'(busy),       32'd0);
    tick(5);

    // 2: in-progress replies keep the transaction open
    send_cmd(16'hC381, t0);
    wait_snt(ts);
    chk("t2_byte_hi", 32'(tx_q[0]), 32'hC3);
    chk("t2_byte_lo", 32'(tx_q[1]), 32'h81);
    tx_q.delete();
    n = rdy_cnt;
    send_rx(RESP_PROG, 1'b1);
    tick(2);
    chk("t2_busy_p1", 32'(busy),        32'd1);
    chk("t2_resp_p1", 32'(resp),        32'(RESP_PROG));
    chk("t2_rdy_p1",  32'(rdy_cnt - n), 32'd1);
    send_rx(RESP_PROG, 1'b1);
    tick(2);
    chk("t2_busy_p2", 32'(busy),        32'd1);
    send_rx(RESP_DONE, 1'b1);
    tick(2);
    chk("t2_rdy_cnt", 32'(rdy_cnt - n), 32'd3);
    chk("t2_busy_end", 32'(busy),       32'd0);
    chk("t2_resp",    32'(resp),        32'(RESP_DONE));
    tick(5);

    // 3: snd_cmd while busy is ignored and does not disturb the latched command
    send_cmd(16'h0F81, t0);
    tick(40);
    cmd = 16'hFFFF; snd_cmd = 1'b1;
    tick(1);
    snd_cmd = 1'b0; cmd = 16'h0000;
    wait_snt(ts);
    chk("t3_snt_lat", 32'(ts - t0),  32'd321);
    chk("t3_byte_hi", 32'(tx_q[0]), 32'h0F);
    chk("t3_byte_lo", 32'(tx_q[1]), 32'h81);
    tx_q.delete();
    send_rx(RESP_DONE, 1'b1);
    tick(2);
    chk("t3_busy_end", 32'(busy), 32'd0);
    n = snt_cnt;
    tick(400);
    chk("t3_no_resend", 32'(snt_cnt - n),  32'd0);
    chk("t3_tx_quiet",  32'(tx_q.size()), 32'd0);

    // 4: framing error is dropped, a good byte afterwards closes the transaction
    send_cmd(16'h3C3C, t0);
    wait_snt(ts);
    tx_q.delete();
    n = rdy_cnt;
    send_rx(8'h33, 1'b0);
    tick(BD);
    chk("t4_ferr_rdy",  32'(rdy_cnt - n), 32'd0);
    chk("t4_ferr_busy", 32'(busy),        32'd1);
    chk("t4_ferr_resp", 32'(resp),        32'(RESP_DONE));
    send_rx(RESP_DONE, 1'b1);
    tick(2);
    chk("t4_rdy_cnt",  32'(rdy_cnt - n), 32'd1);
    chk("t4_busy_end", 32'(busy),        32'd0);

    // 5: reset mid low byte, then a clean command
    send_cmd(16'hBEEF, t0);
    tick(200);
    rst = 1'b1;
    tick(1);
    chk("t5_rst_tx",   32'(TX),   32'd1);
    chk("t5_rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    tick(2);
    chk("t5_tx_idle",  32'(TX),   32'd1);
    tx_q.delete();
    send_cmd(16'h0001, t0);
    chk("t5_tx_start", 32'(TX), 32'd0);
    wait_snt(ts);
    chk("t5_snt_lat",  32'(ts - t0),     32'd321);
    chk("t5_nbytes",   32'(tx_q.size()), 32'd2);
    chk("t5_byte_hi",  32'(tx_q[0]),     32'h00);
    chk("t5_byte_lo",  32'(tx_q[1]),     32'h01);
    tx_q.delete();
    send_rx(RESP_DONE, 1'b1);
    tick(2);
    chk("t5_busy_end", 32'(busy), 32'd0);
    chk("tx_frames_ok", 32'(tx_frm_bad), 32'd0);
    tick(5);

    // 6: no reply
    n = to_cnt;
    send_cmd(16'h0102, t0);
    wait_snt(ts);
`ifdef RESP_TIMEOUT_EN
    tt = -1;
    for (int i = 0; i < 2100; i++) begin
      @(negedge clk);
      if (timeout === 1'b1) begin
        tt = cyc;
        break;
      end
    end
    chk("t6_to_lat",  32'(tt - ts), 32'd2000);
    chk("t6_busy",    32'(busy),    32'd0);
    chk("t6_resp",    32'(resp),    32'(RESP_DONE));
    tick(2);
    chk("t6_to_cnt",  32'(to_cnt - n), 32'd1);
`else
    tt = 0;
    tick(10000);
    chk("t6_busy",    32'(busy),       32'd1);
    chk("t6_to_cnt",  32'(to_cnt - n), 32'd0);
    chk("t6_timeout", 32'(timeout),    32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
